// File: rtl/cache_fill_ctrl.sv
// Purpose : miss-handling engine; picks a victim, writes it back if valid and dirty, refills, installs, marks it MRU.
// Latency : miss at T -> fill_done at T+3 (clean victim) or T+4 (dirty victim), when mem_ack comes on the first request cycle.
// Backpressure: one miss outstanding; miss_ready only in IDLE; mem_req and its payload are held until mem_ack.
// Ports:
//   clock/reset            : single clock, synchronous active-high reset
//   miss_*                 : incoming miss (set, tag) with ready
//   victim_* / way_*       : victim query to the LRU block and the array contents of the chosen way
//   mem_*                  : memory port (writeback or refill), req held until ack
//   fill_* / update_*      : install strobe to the tag/data arrays and MRU update to the LRU block
module cache_fill_ctrl #(
  parameter int NUM_SET        = 4,
  parameter int WAYS_PER_SET   = 4,
  parameter int TAG_W          = 26,
  parameter int LINE_W         = 128,
  parameter int NUM_SET_W      = $clog2(NUM_SET),
  parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss_req,
  input  logic [NUM_SET_W-1:0]      miss_set,
  input  logic [TAG_W-1:0]          miss_tag,
  output logic                      miss_ready,
  output logic                      victim_req,
  output logic [NUM_SET_W-1:0]      victim_set,
  input  logic [WAYS_PER_SET_W-1:0] victim_way,
  input  logic                      way_valid,
  input  logic                      way_dirty,
  input  logic [TAG_W-1:0]          way_tag,
  input  logic [LINE_W-1:0]         way_data,
  output logic                      mem_req,
  output logic                      mem_write,
  output logic [NUM_SET_W-1:0]      mem_set,
  output logic [TAG_W-1:0]          mem_tag,
  output logic [LINE_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [LINE_W-1:0]         mem_rdata,
  output logic                      fill_we,
  output logic [NUM_SET_W-1:0]      fill_set,
  output logic [WAYS_PER_SET_W-1:0] fill_way,
  output logic [TAG_W-1:0]          fill_tag,
  output logic [LINE_W-1:0]         fill_data,
  output logic                      update_req,
  output logic [NUM_SET_W-1:0]      update_set,
  output logic [WAYS_PER_SET_W-1:0] update_way,
  output logic                      fill_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VICTIM  = 3'd1,
    S_WB      = 3'd2,
    S_REFILL  = 3'd3,
    S_INSTALL = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [NUM_SET_W-1:0]      set_q;
  logic [TAG_W-1:0]          tag_q;
  logic [WAYS_PER_SET_W-1:0] vway_q;
  logic [TAG_W-1:0]          vtag_q;
  logic [LINE_W-1:0]         vdata_q;
  logic [LINE_W-1:0]         rdata_q;

  // State register plus the miss/victim/refill capture registers.
  // Victim fields are snapshotted in VICTIM so later array writes cannot
  // disturb the writeback payload or the install way.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      vway_q  <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (miss_req) begin
          set_q <= miss_set;
          tag_q <= miss_tag;
        end
        S_VICTIM: begin
          vway_q  <= victim_way;
          vtag_q  <= way_tag;
          vdata_q <= way_data;
        end
        S_REFILL: if (mem_ack) rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Next-state logic. The writeback decision uses the live way bits in the
  // VICTIM cycle itself; an invalid way never writes back, whatever its dirty bit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (miss_req) state_nxt = S_VICTIM;
      S_VICTIM:  state_nxt = (way_valid && way_dirty) ? S_WB : S_REFILL;
      S_WB:      if (mem_ack) state_nxt = S_REFILL;
      S_REFILL:  if (mem_ack) state_nxt = S_INSTALL;
      S_INSTALL: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state and registered payloads; every payload
  // is forced to zero whenever its strobe is low.
  always_comb begin
    miss_ready = 1'b0;
    victim_req = 1'b0;
    victim_set = '0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_set    = '0;
    mem_tag    = '0;
    mem_wdata  = '0;
    fill_we    = 1'b0;
    fill_set   = '0;
    fill_way   = '0;
    fill_tag   = '0;
    fill_data  = '0;
    update_req = 1'b0;
    update_set = '0;
    update_way = '0;
    fill_done  = 1'b0;
    case (state)
      S_IDLE: miss_ready = 1'b1;
      S_VICTIM: begin
        victim_req = 1'b1;
        victim_set = set_q;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_set   = set_q;
        mem_tag   = vtag_q;
        mem_wdata = vdata_q;
      end
      S_REFILL: begin
        mem_req = 1'b1;
        mem_set = set_q;
        mem_tag = tag_q;
      end
      S_INSTALL: begin
        fill_we    = 1'b1;
        fill_set   = set_q;
        fill_way   = vway_q;
        fill_tag   = tag_q;
        fill_data  = rdata_q;
        update_req = 1'b1;
        update_set = set_q;
        update_way = vway_q;
        fill_done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Purpose : directed self-checking bench for cache_fill_ctrl.
// Latency : each scenario steps cycle by cycle and compares against hand-computed values.
// Backpressure: mem_ack is driven by the bench with chosen delays.
module tb_cache_fill_ctrl;
  localparam int NUM_SET = 4, WAYS_PER_SET = 4, TAG_W = 26, LINE_W = 128;
  localparam int SW = 2, WW = 2;

  logic clk, reset;
  logic miss_req; logic [SW-1:0] miss_set; logic [TAG_W-1:0] miss_tag; logic miss_ready;
  logic victim_req; logic [SW-1:0] victim_set; logic [WW-1:0] victim_way;
  logic way_valid, way_dirty; logic [TAG_W-1:0] way_tag; logic [LINE_W-1:0] way_data;
  logic mem_req, mem_write; logic [SW-1:0] mem_set; logic [TAG_W-1:0] mem_tag;
  logic [LINE_W-1:0] mem_wdata; logic mem_ack; logic [LINE_W-1:0] mem_rdata;
  logic fill_we; logic [SW-1:0] fill_set; logic [WW-1:0] fill_way; logic [TAG_W-1:0] fill_tag;
  logic [LINE_W-1:0] fill_data; logic update_req; logic [SW-1:0] update_set; logic [WW-1:0] update_way;
  logic fill_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fd_cnt = 0;
  int wr_cnt = 0;

  localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_RD = {4{32'hCAFE_0001}};

  cache_fill_ctrl #(.NUM_SET(NUM_SET), .WAYS_PER_SET(WAYS_PER_SET), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clock(clk), .reset(reset),
    .miss_req(miss_req), .miss_set(miss_set), .miss_tag(miss_tag), .miss_ready(miss_ready),
    .victim_req(victim_req), .victim_set(victim_set), .victim_way(victim_way),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tag(way_tag), .way_data(way_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_set(mem_set), .mem_tag(mem_tag),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
    .fill_data(fill_data), .update_req(update_req), .update_set(update_set),
    .update_way(update_way), .fill_done(fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  // Also tallies fill_done pulses and writeback cycles seen.
  task automatic tick();
    @(posedge clk); #1;
    if (fill_done === 1'b1) fd_cnt++;
    if (mem_req === 1'b1 && mem_write === 1'b1) wr_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b1; miss_req = 1'b1;
    repeat (3) tick();
    total_cnt++; if (miss_ready !== 1'b1) $display("FAIL reset_miss_ready got %0b want 1", miss_ready); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else pass_cnt++;
    total_cnt++; if (fill_we !== 1'b0) $display("FAIL reset_fill_we got %0b want 0", fill_we); else pass_cnt++;
    total_cnt++; if (update_req !== 1'b0) $display("FAIL reset_update_req got %0b want 0", update_req); else pass_cnt++;
    total_cnt++; if (fill_done !== 1'b0 || victim_req !== 1'b0) $display("FAIL reset_done_victim got %0b%0b want 00", fill_done, victim_req); else pass_cnt++;
    reset = 1'b0; mem_ack = 1'b0; miss_req = 1'b0;
    tick();
  endtask

  // Clean (invalid) victim with a dirty bit set that must be ignored.
  task automatic test_clean_miss();
    fd_cnt = 0; wr_cnt = 0;
    miss_req = 1'b1; miss_set = 2'd2; miss_tag = 26'h155;
    victim_way = 2'd3; way_valid = 1'b0; way_dirty = 1'b1; way_tag = 26'h3FF; way_data = '1;
    tick(); // T+1
    miss_req = 1'b0;
    total_cnt++; if (victim_req !== 1'b1 || victim_set !== 2'd2) $display("FAIL clean_victim got req=%0b set=%0d want 1/2", victim_req, victim_set); else pass_cnt++;
    total_cnt++; if (miss_ready !== 1'b0) $display("FAIL clean_busy got %0b want 0", miss_ready); else pass_cnt++;
    tick(); // T+2
    total_cnt++; if (mem_req !== 1'b1 || mem_write !== 1'b0) $display("FAIL clean_refill_req got %0b/%0b want 1/0", mem_req, mem_write); else pass_cnt++;
    total_cnt++; if (mem_tag !== 26'h155 || mem_set !== 2'd2 || mem_wdata !== '0) $display("FAIL clean_refill_payload got tag=%0h set=%0d want 155/2", mem_tag, mem_set); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = PAT_A5; way_data = '0; victim_way = 2'd0;
    tick(); // T+3
    total_cnt++; if (fill_we !== 1'b1 || update_req !== 1'b1 || fill_done !== 1'b1) $display("FAIL clean_install_strobes got %0b%0b%0b want 111", fill_we, update_req, fill_done); else pass_cnt++;
    total_cnt++; if (fill_set !== 2'd2 || fill_way !== 2'd3 || update_set !== 2'd2 || update_way !== 2'd3) $display("FAIL clean_install_where got %0d/%0d %0d/%0d want 2/3 2/3", fill_set, fill_way, update_set, update_way); else pass_cnt++;
    total_cnt++; if (fill_data !== PAT_A5 || fill_tag !== 26'h155) $display("FAIL clean_install_data got tag=%0h data=%0h", fill_tag, fill_data); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL clean_install_mem_req got %0b want 0", mem_req); else pass_cnt++;
    tick(); // T+4, ack still high but must be ignored in INSTALL/IDLE
    mem_ack = 1'b0;
    total_cnt++; if (miss_ready !== 1'b1 || fill_done !== 1'b0 || fd_cnt != 1 || wr_cnt != 0) $display("FAIL clean_after got ready=%0b done=%0b fd=%0d wr=%0d want 1/0/1/0", miss_ready, fill_done, fd_cnt, wr_cnt); else pass_cnt++;
  endtask

  // Dirty victim, acks after 3 idle cycles, a stray miss during WB, then a back-to-back miss.
  task automatic test_dirty_wb();
    fd_cnt = 0;
    miss_req = 1'b1; miss_set = 2'd1; miss_tag = 26'h3333;
    victim_way = 2'd0; way_valid = 1'b1; way_dirty = 1'b1; way_tag = 26'h0AA; way_data = 128'h1234;
    tick(); // VICTIM
    miss_req = 1'b0;
    total_cnt++; if (victim_req !== 1'b1 || victim_set !== 2'd1) $display("FAIL dirty_victim got %0b/%0d want 1/1", victim_req, victim_set); else pass_cnt++;
    tick(); // WB cycle 1
    way_tag = 26'h111; way_data = 128'h9999; victim_way = 2'd2; way_dirty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      miss_req = (i == 0); miss_set = 2'd3; miss_tag = 26'h777;
      total_cnt++; if (mem_req !== 1'b1 || mem_write !== 1'b1 || mem_tag !== 26'h0AA || mem_wdata !== 128'h1234 || mem_set !== 2'd1 || miss_ready !== 1'b0)
        $display("FAIL dirty_wb_hold cyc%0d got req=%0b wr=%0b tag=%0h wdata=%0h set=%0d", i, mem_req, mem_write, mem_tag, mem_wdata, mem_set); else pass_cnt++;
      mem_ack = (i == 3);
      tick();
    end
    miss_req = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (mem_req !== 1'b1 || mem_write !== 1'b0 || mem_tag !== 26'h3333 || mem_wdata !== '0 || mem_set !== 2'd1)
        $display("FAIL dirty_refill_hold cyc%0d got req=%0b wr=%0b tag=%0h set=%0d", i, mem_req, mem_write, mem_tag, mem_set); else pass_cnt++;
      mem_ack = (i == 3); mem_rdata = PAT_RD;
      tick();
    end
    mem_ack = 1'b0;
    total_cnt++; if (fill_done !== 1'b1 || fill_way !== 2'd0 || fill_set !== 2'd1 || fill_tag !== 26'h3333 || fill_data !== PAT_RD)
      $display("FAIL dirty_install got done=%0b way=%0d set=%0d tag=%0h", fill_done, fill_way, fill_set, fill_tag); else pass_cnt++;
    // Present the next miss while INSTALL is showing: must not be taken.
    miss_req = 1'b1; miss_set = 2'd0; miss_tag = 26'h42; way_valid = 1'b0; victim_way = 2'd1;
    tick(); // IDLE (fill_done+1): miss accepted here
    total_cnt++; if (miss_ready !== 1'b1 || fd_cnt != 1) $display("FAIL b2b_idle got ready=%0b fd=%0d want 1/1", miss_ready, fd_cnt); else pass_cnt++;
    tick(); // VICTIM
    miss_req = 1'b0;
    total_cnt++; if (victim_req !== 1'b1 || victim_set !== 2'd0) $display("FAIL b2b_victim got %0b/%0d want 1/0", victim_req, victim_set); else pass_cnt++;
    tick(); // REFILL
    mem_ack = 1'b1; mem_rdata = PAT_A5;
    tick(); // INSTALL
    mem_ack = 1'b0;
    total_cnt++; if (fill_done !== 1'b1 || fill_way !== 2'd1 || fill_tag !== 26'h42 || fd_cnt != 2) $display("FAIL b2b_install got done=%0b way=%0d tag=%0h fd=%0d", fill_done, fill_way, fill_tag, fd_cnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_in_refill();
    fd_cnt = 0;
    miss_req = 1'b1; miss_set = 2'd3; miss_tag = 26'h5A5A; victim_way = 2'd2; way_valid = 1'b0; way_dirty = 1'b0;
    tick(); miss_req = 1'b0;
    tick(); // REFILL, no ack
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL rst_refill_pre got %0b want 1", mem_req); else pass_cnt++;
    reset = 1'b1; mem_ack = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    total_cnt++; if (miss_ready !== 1'b1 || mem_req !== 1'b0 || fill_we !== 1'b0) $display("FAIL rst_refill_idle got ready=%0b req=%0b we=%0b", miss_ready, mem_req, fill_we); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (fd_cnt != 0) $display("FAIL rst_refill_no_done got %0d want 0", fd_cnt); else pass_cnt++;
    miss_req = 1'b1; miss_set = 2'd2; miss_tag = 26'h7;
    tick(); miss_req = 1'b0;
    tick(); mem_ack = 1'b1; mem_rdata = PAT_RD;
    tick(); mem_ack = 1'b0;
    total_cnt++; if (fill_done !== 1'b1 || fill_set !== 2'd2 || fill_tag !== 26'h7 || fill_way !== 2'd2 || fill_data !== PAT_RD)
      $display("FAIL rst_recover got done=%0b set=%0d tag=%0h way=%0d", fill_done, fill_set, fill_tag, fill_way); else pass_cnt++;
    tick();
  endtask

  // Valid but clean victim, ack held high throughout.
  task automatic test_valid_clean();
    wr_cnt = 0;
    mem_ack = 1'b1; mem_rdata = PAT_A5;
    miss_req = 1'b1; miss_set = 2'd0; miss_tag = 26'h2BAD; victim_way = 2'd1; way_valid = 1'b1; way_dirty = 1'b0;
    tick(); miss_req = 1'b0; // T+1
    total_cnt++; if (victim_req !== 1'b1 || fill_done !== 1'b0) $display("FAIL vclean_t1 got req=%0b done=%0b want 1/0", victim_req, fill_done); else pass_cnt++;
    tick(); // T+2
    total_cnt++; if (mem_req !== 1'b1 || mem_write !== 1'b0 || mem_tag !== 26'h2BAD) $display("FAIL vclean_t2 got req=%0b wr=%0b tag=%0h", mem_req, mem_write, mem_tag); else pass_cnt++;
    tick(); // T+3
    total_cnt++; if (fill_done !== 1'b1 || fill_way !== 2'd1 || wr_cnt != 0) $display("FAIL vclean_t3 got done=%0b way=%0d wr=%0d want 1/1/0", fill_done, fill_way, wr_cnt); else pass_cnt++;
    tick();
    mem_ack = 1'b0;
    total_cnt++; if (miss_ready !== 1'b1 || fill_done !== 1'b0) $display("FAIL vclean_after got ready=%0b done=%0b", miss_ready, fill_done); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_set = '0; miss_tag = '0;
    victim_way = '0; way_valid = 1'b0; way_dirty = 1'b0; way_tag = '0; way_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_clean_miss();
    test_dirty_wb();
    test_reset_in_refill();
    test_valid_clean();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling engine that drives the victim-search and LRU-update side of the per-set LRU block.
- Accepts one cache miss at a time, requests a victim way, and writes the victim back to memory if it is valid and dirty.
- Refills the line from memory, installs it in the data/tag arrays, and marks the installed way most-recent.
- Sits between the cache lookup pipeline, the LRU block, the tag/data arrays and the memory request port.

Parameters:
- NUM_SET, 4, number of cache sets.
- WAYS_PER_SET, 4, ways per set.
- TAG_W, 26, tag width.
- LINE_W, 128, cache line width in bits.
- NUM_SET_W, $clog2(NUM_SET), set index width.
- WAYS_PER_SET_W, $clog2(WAYS_PER_SET), way index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- miss_req  in  1  miss request, accepted only when miss_ready=1
- miss_set  in  NUM_SET_W  set index of the missing line
- miss_tag  in  TAG_W  tag of the missing line
- miss_ready  out  1  high only in IDLE
- victim_req  out  1  victim search request to the LRU
- victim_set  out  NUM_SET_W  set to search
- victim_way  in  WAYS_PER_SET_W  LRU answer, combinational, same cycle
- way_valid  in  1  valid bit of (victim_set, victim_way), combinational
- way_dirty  in  1  dirty bit of the same entry
- way_tag  in  TAG_W  tag of the same entry
- way_data  in  LINE_W  data of the same entry
- mem_req  out  1  memory request, held until mem_ack
- mem_write  out  1  1 = writeback, 0 = refill read
- mem_set  out  NUM_SET_W  set index of the memory request
- mem_tag  out  TAG_W  tag of the memory request
- mem_wdata  out  LINE_W  writeback data
- mem_ack  in  1  request complete; mem_rdata is valid when mem_write=0
- mem_rdata  in  LINE_W  refill data
- fill_we  out  1  write strobe to the tag/data arrays (also sets valid, clears dirty)
- fill_set  out  NUM_SET_W  set written by fill_we
- fill_way  out  WAYS_PER_SET_W  way written by fill_we
- fill_tag  out  TAG_W  tag written by fill_we
- fill_data  out  LINE_W  data written by fill_we
- update_req  out  1  LRU update request
- update_set  out  NUM_SET_W  set to update
- update_way  out  WAYS_PER_SET_W  way to mark most-recent
- fill_done  out  1  one-cycle pulse when the line is installed

Behaviour:
- One clock; reset synchronous, active-high.
- Reset: state=IDLE, every output 0 except miss_ready=1, and all internal registers cleared.
- States: IDLE, VICTIM, WB, REFILL, INSTALL.
- IDLE: miss_ready=1. miss_req=1 latches miss_set/miss_tag and moves to VICTIM.
- VICTIM (exactly 1 cycle):
  - victim_req=1 and victim_set=latched set.
  - Latch victim_way, way_valid, way_dirty, way_tag and way_data.
  - If valid&dirty, go to WB; otherwise go to REFILL.
- WB:
  - mem_req=1, mem_write=1, mem_set=latched set, mem_tag=victim tag, mem_wdata=victim data.
  - mem_ack=1 moves to REFILL.
- REFILL:
  - mem_req=1, mem_write=0, mem_tag=miss tag, mem_wdata=0.
  - On mem_ack=1, latch mem_rdata and move to INSTALL.
- INSTALL (exactly 1 cycle):
  - fill_we=1, update_req=1 and fill_done=1, all in the same cycle.
  - fill_set=update_set=latched set; fill_way=update_way=victim way; fill_tag=miss tag; fill_data=refill data.
  - Then return to IDLE.
- Handshake:
  - mem_req and its payload stay stable from assertion until the mem_ack cycle inclusive.
  - mem_ack is allowed in the first request cycle.
  - mem_ack in IDLE, VICTIM or INSTALL is ignored.
- Latency, with miss accepted at cycle T and ack at the first request cycle:
  - Clean victim: REFILL at T+2, INSTALL/fill_done at T+3.
  - Dirty victim: WB at T+2, REFILL at T+3, fill_done at T+4.
- Only one miss is outstanding. miss_req while miss_ready=0 is ignored and not queued.
- Back-to-back misses: the cycle after INSTALL is IDLE, so the next miss is accepted at fill_done+1.
- Invalid victim: dirty is ignored and there is no writeback.
- All victim fields are captured in VICTIM. Array changes after that cycle do not affect WB or INSTALL.
- Reset in any state (including with mem_req high): next cycle IDLE, mem_req=0, and no fill_we/update_req/fill_done is issued.
- Output qualification: all outputs are registered or decoded from state; payload outputs are 0 when their strobe is low.

Test Plan:
- Reset hold with mem_ack=1 -> miss_ready=1, mem_req=0, fill_we=0, update_req=0, fill_done=0.
- Clean miss: set=2, tag=0x155, victim_way=3, way_valid=0; ack in first REFILL cycle; mem_rdata=0xA5..A5 -> victim_req at T+1; mem_req/mem_write=0/mem_tag=0x155 at T+2; fill_we/update_req at T+3 with set=2, way=3, data 0xA5..A5.
- Dirty victim: set=1, way=0, way_tag=0x0AA, dirty=1, way_data=0x1234; mem_ack delayed 3 cycles per request -> WB holds mem_write=1, mem_tag=0x0AA, mem_wdata=0x1234 stable for 4 cycles; REFILL follows with new tag; fill_done once.
- miss_req pulsed during WB -> ignored; exactly one fill_done; a second miss accepted only the cycle after fill_done.
- Reset asserted in REFILL with mem_req=1 -> next cycle IDLE, mem_req=0, no fill_done; a new miss completes normally.
- Valid but clean victim (valid=1, dirty=0) -> no mem_write=1 cycle; fill_done at T+3.
